// File: rtl/core_if_id_ibuf_pkg.sv
// Core-wide defines and shared types for the fetch->decode instruction buffer.
//   CORE_INST_WIDTH / CORE_PC_WIDTH : instruction and PC widths
//   CORE_NOP_INST                   : instruction presented while the buffer is empty
//   CORE_IBUF_DEPTH                 : default instruction-buffer depth
// The package carries the buffer entry layout and the idle (empty) head value.
`ifndef CORE_DEFINES_V
`define CORE_DEFINES_V
`define CORE_INST_WIDTH 32
`define CORE_PC_WIDTH   32
`define CORE_NOP_INST   32'h00000013
`define CORE_IBUF_DEPTH 4
`endif

package core_if_id_ibuf_pkg;

  localparam int unsigned INST_W = `CORE_INST_WIDTH;
  localparam int unsigned PC_W   = `CORE_PC_WIDTH;

  localparam logic [INST_W-1:0] NOP_INST = `CORE_NOP_INST;

  // One buffered fetch result: instruction, its PC and the fetch-time prediction.
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic              bj_pred;
  } ibuf_entry_t;

  // Head value shown to decode when nothing is buffered.
  function automatic ibuf_entry_t idle_entry();
    ibuf_entry_t e;
    e.inst    = NOP_INST;
    e.pc      = '0;
    e.bj_pred = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/core_if_id_ibuf.sv
// Instruction buffer between fetch and decode: a circular FIFO of
// {instruction, PC, prediction bit} with valid/ready handshakes on both sides
// and a flush input that discards all buffered entries.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_in / ready_in        fetch-side handshake (ready_in = not full)
//   i_inst, i_pc, i_branch_jump_predict   pushed entry
//   valid_out / ready_out      decode-side handshake (valid_out = not empty)
//   o_inst, o_pc, o_branch_jump_predict   head entry (NOP/0/0 when empty)
//   i_pipe_flush_req           discard everything at the next edge
//   o_occupancy                registered number of valid entries
module core_if_id_ibuf
  import core_if_id_ibuf_pkg::*;
#(
  parameter int unsigned DEPTH = `CORE_IBUF_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [`CORE_INST_WIDTH-1:0] i_inst,
  input  logic [`CORE_PC_WIDTH-1:0]   i_pc,
  input  logic                        i_branch_jump_predict,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic [`CORE_INST_WIDTH-1:0] o_inst,
  output logic [`CORE_PC_WIDTH-1:0]   o_pc,
  output logic                        o_branch_jump_predict,
  input  logic                        i_pipe_flush_req,
  output logic [PTR_W:0]              o_occupancy
);

  localparam int unsigned ENTRY_W = INST_W + PC_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;

  // Storage is deliberately left unreset; count gates its visibility.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  ibuf_entry_t entry_in;
  ibuf_entry_t head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_FULL);

  // Both handshake outputs come from registered state only.
  assign ready_in  = ~full;
  assign valid_out = ~empty;

  assign push = valid_in  & ~full  & ~i_pipe_flush_req;
  assign pop  = ready_out & ~empty & ~i_pipe_flush_req;

  assign entry_in.inst    = i_inst;
  assign entry_in.pc      = i_pc;
  assign entry_in.bj_pred = i_branch_jump_predict;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_pipe_flush_req) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  assign head = empty ? idle_entry() : ibuf_entry_t'(mem_q[rd_ptr_q]);

  assign o_inst                = head.inst;
  assign o_pc                  = head.pc;
  assign o_branch_jump_predict = head.bj_pred;
  assign o_occupancy           = count_q;

endmodule

// File: tb/tb_core_if_id_ibuf.sv
module tb_core_if_id_ibuf;
  import core_if_id_ibuf_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] i_inst;
  logic [31:0] i_pc;
  logic        i_bjp;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] o_inst;
  logic [31:0] o_pc;
  logic        o_bjp;
  logic        flush;
  logic [2:0]  o_occupancy;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        bjp;
  } exp_t;

  exp_t exp_q[$];
  int   mcount;
  int   total;
  int   bad;

  core_if_id_ibuf #(.DEPTH(4), .PTR_W(2)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .valid_in              (valid_in),
    .ready_in              (ready_in),
    .i_inst                (i_inst),
    .i_pc                  (i_pc),
    .i_branch_jump_predict (i_bjp),
    .valid_out             (valid_out),
    .ready_out             (ready_out),
    .o_inst                (o_inst),
    .o_pc                  (o_pc),
    .o_branch_jump_predict (o_bjp),
    .i_pipe_flush_req      (flush),
    .o_occupancy           (o_occupancy)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic bjp, input logic rdy, input logic fl);
    valid_in  = v;
    i_pc      = pc;
    i_inst    = inst;
    i_bjp     = bjp;
    ready_out = rdy;
    flush     = fl;
  endtask

  // Reference model: decides transfers from the bench's own occupancy,
  // updates the scoreboard, then steps one clock and settles 1 time unit.
  task automatic advance();
    logic push;
    logic pop;
    exp_t e;
    push = valid_in && (mcount < DEPTH) && !flush;
    pop  = (mcount != 0) && ready_out && !flush;
    if (flush) begin
      exp_q.delete();
      mcount = 0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (push) begin
        e.inst = i_inst;
        e.pc   = i_pc;
        e.bjp  = i_bjp;
        exp_q.push_back(e);
      end
      mcount = mcount + int'(push) - int'(pop);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    mcount = 0;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid_out: got=%b need=0", valid_out); end
    total++; if (ready_in !== 1'b1) begin bad++; $display("FAIL rst_ready_in: got=%b need=1", ready_in); end
    total++; if (o_inst !== NOP) begin bad++; $display("FAIL rst_o_inst: got=%h need=%h", o_inst, NOP); end
    total++; if (o_pc !== 32'h0) begin bad++; $display("FAIL rst_o_pc: got=%h need=0", o_pc); end
    total++; if (o_occupancy !== 3'd0) begin bad++; $display("FAIL rst_occ: got=%0d need=0", o_occupancy); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    advance();
    advance();
    total++; if (valid_out !== 1'b0 || ready_in !== 1'b1 || o_inst !== NOP || o_pc !== 32'h0 || o_bjp !== 1'b0)
      begin bad++; $display("FAIL idle_after_rst: valid=%b ready=%b inst=%h pc=%h bjp=%b need 0/1/%h/0/0", valid_out, ready_in, o_inst, o_pc, o_bjp, NOP); end
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h80000000 + 32'(4 * i), $urandom, 1'(i), 1'b0, 1'b0);
      advance();
      total++; if (o_occupancy !== 3'(mcount)) begin bad++; $display("FAIL fill_occ[%0d]: got=%0d need=%0d", i, o_occupancy, mcount); end
    end
    total++; if (ready_in !== 1'b0) begin bad++; $display("FAIL full_ready_in: got=%b need=0", ready_in); end
    total++; if (o_occupancy !== 3'd4) begin bad++; $display("FAIL full_occ: got=%0d need=4", o_occupancy); end
    drive(1'b1, 32'h80000010, $urandom, 1'b1, 1'b0, 1'b0);
    advance();
    total++; if (o_occupancy !== 3'd4 || o_pc !== 32'h80000000) begin bad++; $display("FAIL fifth_push: occ=%0d pc=%h need 4/80000000", o_occupancy, o_pc); end
    // drain with the scoreboard
    for (int n = 0; n < 8 && mcount != 0; n++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      total++;
      if (o_pc !== exp_q[0].pc || o_inst !== exp_q[0].inst || o_bjp !== exp_q[0].bjp || valid_out !== 1'b1) begin
        bad++; $display("FAIL fill_drain_head: v=%b pc=%h inst=%h bjp=%b need v=1 pc=%h inst=%h bjp=%b",
                        valid_out, o_pc, o_inst, o_bjp, exp_q[0].pc, exp_q[0].inst, exp_q[0].bjp);
      end
      advance();
    end
    total++; if (valid_out !== 1'b0 || o_occupancy !== 3'd0) begin bad++; $display("FAIL fill_drained: valid=%b occ=%0d need 0/0", valid_out, o_occupancy); end
  endtask

  task automatic test_simul_push_pop();
    drive(1'b1, 32'h100, 32'h00A00093, 1'b0, 1'b0, 1'b0);
    advance();
    total++; if (o_occupancy !== 3'd1 || o_pc !== 32'h100) begin bad++; $display("FAIL simul_setup: occ=%0d pc=%h need 1/100", o_occupancy, o_pc); end
    drive(1'b1, 32'h104, 32'h00B00113, 1'b1, 1'b1, 1'b0);
    total++; if (o_pc !== exp_q[0].pc || o_inst !== exp_q[0].inst) begin bad++; $display("FAIL simul_head: pc=%h inst=%h need %h/%h", o_pc, o_inst, exp_q[0].pc, exp_q[0].inst); end
    advance();
    total++; if (o_occupancy !== 3'd1 || o_pc !== 32'h104 || o_bjp !== 1'b1) begin bad++; $display("FAIL simul_after: occ=%0d pc=%h bjp=%b need 1/104/1", o_occupancy, o_pc, o_bjp); end
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    advance();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL simul_drain: valid=%b need=0", valid_out); end
  endtask

  task automatic test_wrap_order();
    int sent = 0;
    int seen = 0;
    logic rdy = 1'b1;
    for (int cyc = 0; cyc < 60 && seen < 10; cyc++) begin
      if (sent < 10)
        drive(1'b1, 32'(4 * sent), $urandom, 1'(sent % 3 == 0), rdy, 1'b0);
      else
        drive(1'b0, '0, '0, 1'b0, rdy, 1'b0);
      total++; if (valid_out !== (mcount != 0)) begin bad++; $display("FAIL wrap_valid: got=%b need=%b", valid_out, mcount != 0); end
      if (mcount != 0 && rdy) begin
        total++;
        if (o_pc !== 32'(4 * seen) || o_bjp !== 1'(seen % 3 == 0) || o_inst !== exp_q[0].inst) begin
          bad++; $display("FAIL wrap_order[%0d]: pc=%h bjp=%b inst=%h need pc=%h bjp=%b inst=%h",
                          seen, o_pc, o_bjp, o_inst, 32'(4 * seen), seen % 3 == 0, exp_q[0].inst);
        end
        seen++;
      end
      if (sent < 10 && mcount < DEPTH) sent++;
      advance();
      rdy = ~rdy;
    end
    total++; if (seen != 10 || valid_out !== 1'b0) begin bad++; $display("FAIL wrap_complete: seen=%0d valid=%b need 10/0", seen, valid_out); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h180 + 32'(4 * i), $urandom, 1'b0, 1'b0, 1'b0);
      advance();
    end
    total++; if (o_occupancy !== 3'd3) begin bad++; $display("FAIL flush_setup: occ=%0d need=3", o_occupancy); end
    drive(1'b1, 32'h200, $urandom, 1'b1, 1'b1, 1'b1);
    advance();
    total++; if (o_occupancy !== 3'd0 || valid_out !== 1'b0 || ready_in !== 1'b1)
      begin bad++; $display("FAIL flush_clear: occ=%0d valid=%b ready=%b need 0/0/1", o_occupancy, valid_out, ready_in); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h2F0, $urandom, 1'b0, 1'b0, 1'b1);
      advance();
      total++; if (o_occupancy !== 3'd0 || valid_out !== 1'b0) begin bad++; $display("FAIL flush_held[%0d]: occ=%0d valid=%b need 0/0", i, o_occupancy, valid_out); end
    end
    drive(1'b1, 32'h300, 32'h00000513, 1'b0, 1'b0, 1'b0);
    advance();
    drive(1'b1, 32'h304, 32'h00100593, 1'b1, 1'b1, 1'b0);
    total++; if (valid_out !== 1'b1 || o_pc !== 32'h300 || o_inst !== exp_q[0].inst)
      begin bad++; $display("FAIL flush_first_out: valid=%b pc=%h inst=%h need 1/300/%h", valid_out, o_pc, o_inst, exp_q[0].inst); end
    advance();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    total++; if (o_pc !== exp_q[0].pc || o_pc !== 32'h304) begin bad++; $display("FAIL flush_second_out: pc=%h need=304", o_pc); end
    advance();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL flush_drained: valid=%b need=0", valid_out); end
  endtask

  task automatic test_latency();
    drive(1'b1, 32'h40, 32'h12345678, 1'b1, 1'b1, 1'b0);
    total++; if (valid_out !== 1'b0 || o_inst !== NOP) begin bad++; $display("FAIL lat_no_bypass: valid=%b inst=%h need 0/%h", valid_out, o_inst, NOP); end
    advance();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    total++; if (valid_out !== 1'b1 || o_pc !== 32'h40 || o_inst !== 32'h12345678 || o_bjp !== 1'b1)
      begin bad++; $display("FAIL lat_n1: valid=%b pc=%h inst=%h bjp=%b need 1/40/12345678/1", valid_out, o_pc, o_inst, o_bjp); end
    advance();
    total++; if (valid_out !== 1'b0 || o_pc !== 32'h0 || o_inst !== NOP) begin bad++; $display("FAIL lat_n2: valid=%b pc=%h inst=%h need 0/0/%h", valid_out, o_pc, o_inst, NOP); end
  endtask

  task automatic test_reset_midop();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), $urandom, 1'b1, 1'b0, 1'b0);
      advance();
    end
    total++; if (o_occupancy !== 3'd2) begin bad++; $display("FAIL midrst_setup: occ=%0d need=2", o_occupancy); end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    mcount = 0;
    total++; if (valid_out !== 1'b0 || ready_in !== 1'b1 || o_occupancy !== 3'd0 || o_pc !== 32'h0 || o_bjp !== 1'b0)
      begin bad++; $display("FAIL midrst_async: valid=%b ready=%b occ=%0d pc=%h bjp=%b need 0/1/0/0/0", valid_out, ready_in, o_occupancy, o_pc, o_bjp); end
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 32'h600, 32'h00000033, 1'b0, 1'b0, 1'b0);
    advance();
    total++; if (o_occupancy !== 3'd1 || o_pc !== 32'h600) begin bad++; $display("FAIL midrst_resume: occ=%0d pc=%h need 1/600", o_occupancy, o_pc); end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    mcount = 0;
    rst_n  = 1'b1;
    test_reset();
    test_fill_stall();
    test_simul_push_pop();
    test_wrap_order();
    test_flush();
    test_latency();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_if_id_ibuf.md
Name: core_if_id_ibuf

Overview:
- Instruction buffer between the fetch stage and the decode stage.
- Captures each fetched instruction with its PC and the fetch-time branch/jump prediction bit in a small circular FIFO. Presents the oldest entry to decode.
- Decouples fetch from decode stalls with full valid/ready handshakes on both sides.
- On a pipeline flush request from the execute unit, discards every entry it holds.

Parameters:
- DEPTH, 4: number of entries. Must be a power of two and at least 2.
- PTR_W, 2: pointer width, equal to log2(DEPTH).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  fetch stage has an instruction to push
- ready_in  out  1  buffer can accept a push this cycle
- i_inst  in  `CORE_INST_WIDTH  instruction from fetch
- i_pc  in  `CORE_PC_WIDTH  PC of i_inst
- i_branch_jump_predict  in  1  fetch predicted taken branch/jump for i_inst
- valid_out  out  1  head entry is available to decode
- ready_out  in  1  decode accepts the head entry
- o_inst  out  `CORE_INST_WIDTH  head instruction
- o_pc  out  `CORE_PC_WIDTH  head PC
- o_branch_jump_predict  out  1  head prediction bit
- i_pipe_flush_req  in  1  flush from execute; clears the buffer
- o_occupancy  out  PTR_W+1  number of valid entries

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: wr_ptr=0, rd_ptr=0, count=0.
  - Outputs: valid_out=0, ready_in=1, o_occupancy=0, o_inst=`CORE_NOP_INST (32'h00000013), o_pc=0, o_branch_jump_predict=0.
  - Entry storage is not reset.
- Status signals:
  - empty = (count==0); full = (count==DEPTH).
  - ready_in = ~full. There is no combinational path from ready_out to ready_in.
  - valid_out = ~empty. It depends only on registered state.
- Transfer conditions:
  - push = valid_in & ready_in & ~i_pipe_flush_req.
  - pop = valid_out & ready_out & ~i_pipe_flush_req.
- Push: write {i_inst, i_pc, i_branch_jump_predict} to entry[wr_ptr], then wr_ptr += 1.
- Pop: rd_ptr += 1.
- Pointers are PTR_W bits and wrap naturally from DEPTH-1 to 0.
- Count update: count += push - pop.
  - Simultaneous push and pop leaves count unchanged. This is legal at any count below DEPTH.
  - When full, push is blocked even if a pop occurs that cycle.
- Latency: minimum 1 cycle. There is no bypass. An entry pushed at edge N appears at valid_out after edge N+1's evaluation, i.e. in the cycle following the push.
- Head outputs:
  - When ~empty: o_inst, o_pc, o_branch_jump_predict = entry[rd_ptr], read combinationally from registers.
  - When empty: NOP, 0, 0.
- Flush (i_pipe_flush_req=1):
  - At the next edge, wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in the same cycle is ignored.
  - valid_out may still be 1 during the flush cycle; decode must discard it.
  - The cycle after the flush, the buffer is empty and ready_in=1.
- Flush held for several cycles: the buffer stays empty and accepts nothing.
- Reset asserted mid-operation: immediately returns to the reset state, independent of clk.
- Order: strict FIFO. No reordering, duplication or loss except by flush.
- o_occupancy = count, registered.

Decomposition:
- `CORE_NOP_INST, `CORE_INST_WIDTH and `CORE_PC_WIDTH belong in core_defines.v. Add `CORE_IBUF_DEPTH there as the default for DEPTH.
- The entry width is the sum INST+PC+1, computed locally.
- No sub-module. Storage, pointers and count are implemented inline, about 150 lines.

Test Plan:
- Reset and empty: assert rst_n=0 mid-clock -> valid_out=0, ready_in=1, o_inst=32'h00000013, o_pc=0 immediately. After release, the same values hold with no pushes.
- Fill with stall: ready_out=0; push pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C -> o_occupancy reaches 4, ready_in=0. A 5th valid_in is not accepted; o_pc stays 0x80000000.
- Simultaneous push/pop: occupancy 1 (head pc 0x100); push pc 0x104 while ready_out=1 -> occupancy stays 1; next cycle o_pc=0x104.
- Wrap-around order: stream 10 instructions (pc 0x0..0x24) with ready_out toggling 1,0,1,0 -> decode sees PCs strictly in order with the prediction bits preserved, and pointers wrap twice.
- Flush: buffer holds 3 entries; assert i_pipe_flush_req with valid_in=1 (pc 0x200) and ready_out=1 -> next cycle occupancy=0, valid_out=0, and 0x200 never appears. A push of 0x300 the following cycle is output first.
- Latency: empty buffer, ready_out=1, single push of pc 0x40 at cycle N -> valid_out=1 with o_pc=0x40 in cycle N+1 only; empty at N+2.
